sap1_ram_ctrl: RTL and testbench

SAP1_RAM_CTRL -- requirements
Module: sap1_ram_ctrl

---
 rtl/sap1_ram_ctrl.sv | 115 +++++++++++
 tb/tb_sap1_ram_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sap1_ram_ctrl.sv
// sap1_ram_ctrl: arbitrates a 16x8 async SRAM between the SAP-1 CPU and a front-panel programmer.
// Ports:
//   clk, n_rst                       clock, async active-low reset
//   prg_mode                         1 = programmer owns the RAM, 0 = CPU owns it
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata               one-cycle completion pulse, registered read data
//   prg_req/prg_addr/prg_wdata       programmer write request (level, held until prg_ack)
//   prg_ack                          one-cycle completion pulse
//   ram_a/ram_n_ce/ram_n_we          RAM address and active-low strobes
//   ram_d_out/ram_d_oe               data driven onto the RAM bus and its drive enable
//   ram_s                            RAM read data
//   busy                             high outside IDLE
module sap1_ram_ctrl #(
    parameter int WR_PULSE = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       prg_mode,
    input  logic       cpu_req,
    input  logic       cpu_wr,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       prg_req,
    input  logic [3:0] prg_addr,
    input  logic [7:0] prg_wdata,
    output logic       prg_ack,
    output logic [3:0] ram_a,
    output logic       ram_n_ce,
    output logic       ram_n_we,
    output logic [7:0] ram_d_out,
    output logic       ram_d_oe,
    input  logic [7:0] ram_s,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, READ, ACK} state_t;

    state_t     state;
    logic       wr;
    logic       own_prg;
    logic [2:0] cnt;
    logic       take;
    logic       take_wr;

    // Only the current owner's request is visible; the programmer can only write.
    assign take    = prg_mode ? prg_req : cpu_req;
    assign take_wr = prg_mode | cpu_wr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            wr        <= 1'b0;
            own_prg   <= 1'b0;
            cnt       <= 3'd0;
            ram_a     <= 4'd0;
            ram_d_out <= 8'd0;
            ram_n_ce  <= 1'b1;
            ram_n_we  <= 1'b1;
            ram_d_oe  <= 1'b0;
            cpu_rdata <= 8'd0;
            cpu_ack   <= 1'b0;
            prg_ack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            prg_ack <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    state    <= SETUP;
                    busy     <= 1'b1;
                    own_prg  <= prg_mode;
                    wr       <= take_wr;
                    ram_a    <= prg_mode ? prg_addr : cpu_addr;
                    ram_n_ce <= 1'b0;
                    ram_d_oe <= take_wr;
                    if (take_wr)
                        ram_d_out <= prg_mode ? prg_wdata : cpu_wdata;
                end
                SETUP: begin
                    state    <= wr ? WRITE : READ;
                    ram_n_we <= !wr;
                    cnt      <= {2'b00, wr};
                end
                // cnt numbers the strobe cycles 1..WR_PULSE
                WRITE: if (cnt == 3'(WR_PULSE)) begin
                    state    <= HOLD;
                    ram_n_we <= 1'b1;
                    cnt      <= 3'd0;
                end else begin
                    cnt <= cnt + 3'd1;
                end
                HOLD: begin
                    state    <= ACK;
                    ram_n_ce <= 1'b1;
                    ram_d_oe <= 1'b0;
                    prg_ack  <= own_prg;
                    cpu_ack  <= !own_prg;
                end
                READ: begin
                    state     <= ACK;
                    ram_n_ce  <= 1'b1;
                    cpu_rdata <= ram_s;
                    prg_ack   <= own_prg;
                    cpu_ack   <= !own_prg;
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sap1_ram_ctrl.sv
// tb_sap1_ram_ctrl: directed and random transactions on two controllers (WR_PULSE 2 and 1) against a memory model.
module tb_sap1_ram_ctrl;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       prg_mode = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [3:0] cpu_addr = 4'd0;
  logic [7:0] cpu_wdata = 8'd0;
  logic       prg_req = 1'b0;
  logic [3:0] prg_addr = 4'd0;
  logic [7:0] prg_wdata = 8'd0;
  logic       sel = 1'b0;
  logic       cpu_ack[2];
  logic       prg_ack[2];
  logic       ram_n_ce[2];
  logic       ram_n_we[2];
  logic       ram_d_oe[2];
  logic       busy[2];
  logic [3:0] ram_a[2];
  logic [7:0] ram_d_out[2];
  logic [7:0] cpu_rdata[2];
  logic [7:0] ram_s[2];
  logic [7:0] gmem[2][16];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] dmem[16];
    initial for (int i = 0; i < 16; i++) dmem[i] = 8'd0;
    assign ram_s[g] = dmem[ram_a[g]];
    always @(posedge ram_n_we[g])
      if (n_rst && !ram_n_ce[g] && ram_d_oe[g]) dmem[ram_a[g]] <= ram_d_out[g];
    sap1_ram_ctrl #(.WR_PULSE(g == 0 ? 2 : 1)) u_dut (
      .clk(clk), .n_rst(n_rst), .prg_mode(prg_mode),
      .cpu_req(cpu_req & (sel == (g == 1))), .cpu_wr(cpu_wr),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .prg_req(prg_req & (sel == (g == 1))), .prg_addr(prg_addr),
      .prg_wdata(prg_wdata), .prg_ack(prg_ack[g]),
      .ram_a(ram_a[g]), .ram_n_ce(ram_n_ce[g]), .ram_n_we(ram_n_we[g]),
      .ram_d_out(ram_d_out[g]), .ram_d_oe(ram_d_oe[g]),
      .ram_s(ram_s[g]), .busy(busy[g])
    );
  end

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    tests++;
    if (o !== e) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic txn(input bit w, input logic [3:0] a, input logic [7:0] d, input bit hold);
    int wp, lat, nwe, got;
    bit p;
    p   = prg_mode;
    wp  = sel ? 1 : 2;
    lat = w ? 3 + wp : 3;
    if (p) begin
      prg_req = 1'b1; prg_addr = a; prg_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_wr = w; cpu_addr = a; cpu_wdata = d;
    end
    @(posedge clk); #1;
    chk("accept_busy", busy[sel], 1'b1);
    chk("setup_addr", ram_a[sel], a);
    chk("setup_oe", {ram_n_ce[sel], ram_n_we[sel], ram_d_oe[sel]}, {2'b01, w});
    nwe = 0;
    got = 0;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      if (!ram_n_we[sel]) begin
        nwe++;
        chk("we_guard", {ram_n_ce[sel], ram_d_oe[sel], ram_a[sel], ram_d_out[sel]}, {2'b01, a, d});
      end
      if (cpu_ack[sel] | prg_ack[sel]) got = c;
      else begin @(posedge clk); #1; end
    end
    chk("ack_latency", got, lat);
    chk("ack_owner", {prg_ack[sel], cpu_ack[sel]}, p ? 2'b10 : 2'b01);
    chk("we_cycles", nwe, w ? wp : 0);
    chk("ack_bus", {ram_n_ce[sel], ram_n_we[sel], ram_d_oe[sel]}, 3'b110);
    if (w) gmem[sel][a] = d;
    else chk("rdata", cpu_rdata[sel], gmem[sel][a]);
    if (!hold) begin
      if (p) prg_req = 1'b0;
      else cpu_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("idle", {busy[sel], cpu_ack[sel], prg_ack[sel], ram_n_ce[sel], ram_n_we[sel], ram_d_oe[sel]}, 6'b000110);
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) gmem[s][i] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      chk("reset_ctl", {busy[sel], cpu_ack[sel], prg_ack[sel], ram_n_ce[sel], ram_n_we[sel], ram_d_oe[sel]}, 6'b000110);
      chk("reset_data", {ram_a[sel], ram_d_out[sel], cpu_rdata[sel]}, 20'd0);
    end
    sel = 1'b0;
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    prg_mode = 1'b1;
    txn(1'b1, 4'd13, 8'h07, 1'b0);
    prg_mode = 1'b0;
    txn(1'b0, 4'd13, 8'h00, 1'b0);
    prg_req = 1'b1; prg_addr = 4'd5; prg_wdata = 8'hEE;
    txn(1'b1, 4'd5, 8'h5A, 1'b0);
    txn(1'b0, 4'd5, 8'h00, 1'b0);
    prg_req = 1'b0;
    prg_mode = 1'b1;
    fork
      txn(1'b1, 4'd14, 8'h02, 1'b0);
      begin
        @(posedge clk); @(posedge clk); #2;
        chk("mid_write", ram_n_we[0], 1'b0);
        prg_mode = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'd14;
      end
    join
    txn(1'b0, 4'd14, 8'h00, 1'b0);
    prg_mode = 1'b1;
    prg_req = 1'b1; prg_addr = 4'd9; prg_wdata = 8'hAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_write", ram_n_we[0], 1'b0);
    #2 n_rst = 1'b0;
    #1 chk("rst_async", {ram_n_ce[0], ram_n_we[0], ram_d_oe[0], busy[0]}, 4'b1100);
    prg_req = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_no_ack", {cpu_ack[0], prg_ack[0]}, 2'b00);
    end
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    prg_mode = 1'b0;
    txn(1'b0, 4'd9, 8'h00, 1'b0);
    sel = 1'b1;
    txn(1'b1, 4'd15, 8'hFF, 1'b1);
    txn(1'b1, 4'd15, 8'hFF, 1'b0);
    txn(1'b0, 4'd15, 8'h00, 1'b0);
    for (int n = 0; n < 60; n++) begin
      bit w;
      sel = 1'($urandom_range(1));
      prg_mode = 1'($urandom_range(1));
      w = prg_mode | 1'($urandom_range(1));
      if (prg_mode) begin
        cpu_req = 1'($urandom_range(1)); cpu_wr = 1'($urandom_range(1)); cpu_addr = 4'($urandom);
      end else begin
        prg_req = 1'($urandom_range(1)); prg_addr = 4'($urandom); prg_wdata = 8'($urandom);
      end
      txn(w, 4'($urandom), 8'($urandom), 1'b0);
      cpu_req = 1'b0;
      prg_req = 1'b0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
